// File: rtl/karatsuba_bde_factors.sv
// rtl/karatsuba_bde_factors.sv - Karatsuba B/D/E factor generator for 8x8 multiplies.
// Optional KARATSUBA_BDE_ITERATIVE_MUL_EN selects a 4-cycle shift-add multiplier for B.
module karatsuba_bde_factors (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  output logic [9:0] B,
  output logic [4:0] D,
  output logic [4:0] E,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [7:0] xr;
  logic [7:0] yr;
  logic [3:0] xh, xl, yh, yl;
  logic [4:0] dsum;
  logic [4:0] esum;

  assign xh   = xr[7:4];
  assign xl   = xr[3:0];
  assign yh   = yr[7:4];
  assign yl   = yr[3:0];
  assign dsum = {1'b0, xh} + {1'b0, xl};
  assign esum = {1'b0, yh} + {1'b0, yl};

`ifdef KARATSUBA_BDE_ITERATIVE_MUL_EN
  logic [7:0] acc;
  logic [1:0] step;
  logic [7:0] partial;
  logic [7:0] acc_next;

  // One partial product per cycle, yh bit selected by the step counter (LSB first)
  assign partial  = yh[step] ? ({4'b0000, xh} << step) : 8'd0;
  assign acc_next = acc + partial;
`else
  logic [7:0] prod;

  assign prod = {4'b0000, xh} * {4'b0000, yh};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      xr    <= 8'd0;
      yr    <= 8'd0;
      B     <= 10'd0;
      D     <= 5'd0;
      E     <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef KARATSUBA_BDE_ITERATIVE_MUL_EN
      acc   <= 8'd0;
      step  <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= X;
            yr    <= Y;
            busy  <= 1'b1;
            state <= CALC;
`ifdef KARATSUBA_BDE_ITERATIVE_MUL_EN
            acc   <= 8'd0;
            step  <= 2'd0;
`endif
          end
        end
        CALC: begin
`ifdef KARATSUBA_BDE_ITERATIVE_MUL_EN
          if (step == 2'd3) begin
            B     <= {2'b00, acc_next};
            D     <= dsum;
            E     <= esum;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc  <= acc_next;
            step <= step + 2'd1;
          end
`else
          B     <= {2'b00, prod};
          D     <= dsum;
          E     <= esum;
          done  <= 1'b1;
          state <= DONE;
`endif
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_bde_factors.sv
// tb/tb_karatsuba_bde_factors.sv - directed self-checking bench for karatsuba_bde_factors.
module tb_karatsuba_bde_factors;

`ifdef KARATSUBA_BDE_ITERATIVE_MUL_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] X;
  logic [7:0] Y;
  logic [9:0] B;
  logic [4:0] D;
  logic [4:0] E;
  logic       busy;
  logic       done;

  int tests;
  int fails;

  karatsuba_bde_factors dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .X     (X),
    .Y     (Y),
    .B     (B),
    .D     (D),
    .E     (E),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Launch one request and follow it through DONE and back to IDLE
  task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input int eb, input int ed, input int ee, input bit poke);
    int pulses;
    pulses = 0;
    X = x;
    Y = y;
    start = 1'b1;
    tick();
    chk({tag, " busy_after_start"}, busy, 1);
    chk({tag, " done_after_start"}, done, 0);
    start = poke;
    if (poke) X = 8'hFF;
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (done) pulses++;
      if (i == LAT - 1) start = 1'b0;
    end
    chk({tag, " done_at_latency"}, done, 1);
    chk({tag, " busy_in_done"}, busy, 1);
    chk({tag, " B"}, B, eb);
    chk({tag, " D"}, D, ed);
    chk({tag, " E"}, E, ee);
    tick();
    if (done) pulses++;
    chk({tag, " done_cleared"}, done, 0);
    chk({tag, " busy_cleared"}, busy, 0);
    tick();
    if (done) pulses++;
    chk({tag, " stays_idle"}, busy, 0);
    chk({tag, " done_pulses"}, pulses, 1);
  endtask

  initial begin
    int pulses;
    logic [9:0] hb;
    logic [4:0] hd;
    logic [4:0] he;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    X = 8'h00;
    Y = 8'h00;
    @(negedge clock);
    tick();
    tick();
    chk("reset B", B, 0);
    chk("reset D", D, 0);
    chk("reset E", E, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    reset = 1'b0;
    X = 8'h5A;
    Y = 8'hC3;
    repeat (3) tick();
    chk("idle B", B, 0);
    chk("idle busy", busy, 0);

    run("ffff", 8'hFF, 8'hFF, 225, 30, 30, 1'b0);
    run("1234", 8'h12, 8'h34, 3, 3, 7, 1'b0);
    run("a53c", 8'hA5, 8'h3C, 30, 15, 15, 1'b0);

    hb = 10'd30;
    hd = 5'd15;
    he = 5'd15;
    for (int i = 0; i < 10; i++) begin
      X = 8'($urandom);
      Y = 8'($urandom);
      tick();
      chk("hold B", B, hb);
      chk("hold D", D, hd);
      chk("hold E", E, he);
      chk("hold done", done, 0);
    end

    run("009f", 8'h00, 8'h9F, 0, 0, 24, 1'b0);
    run("0ff0", 8'h0F, 8'hF0, 0, 15, 15, 1'b0);
    run("poke", 8'h12, 8'h34, 3, 3, 7, 1'b1);

    // Abort in the first CALC cycle
    X = 8'hFF;
    Y = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort B", B, 0);
    chk("abort D", D, 0);
    chk("abort E", E, 0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort no_done", pulses, 0);
    chk("abort B_held", B, 0);

    run("after_abort", 8'hA5, 8'h3C, 30, 15, 15, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
